// File: rtl/dl_lane_serializer.sv
// Multi-lane downlink serializer: snapshots a tagged message, computes a bit-serial CRC over
// tag/len/payload, then stripes tag, len, payload and CRC across LANES outputs at a
// programmable symbol rate, with optional XOR error injection on the first 64 frame bits.
module dl_lane_serializer #(
    parameter int unsigned          LANES     = 2,
    parameter int unsigned          MAX_BYTES = 16,
    parameter int unsigned          DIV_WIDTH = 8,
    parameter int unsigned          CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT  = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                msg_tag,
    input  logic [7:0]                msg_len,
    input  logic [MAX_BYTES-1:0][7:0] data_in,
    input  logic [DIV_WIDTH-1:0]      ser_clk_div,
    input  logic [31:0]               err_inj_mask_0,
    input  logic [31:0]               err_inj_mask_1,
    input  logic                      err_inj_enable,
    output logic                      err_inj_clear,
    output logic                      busy,
    output logic                      done,
    output logic                      len_err,
    output logic [CRC_WIDTH-1:0]      crc_out,
    output logic [LANES-1:0]          dl_out,
    output logic [LANES-1:0]          dl_en
);

    localparam int unsigned HdrMax   = 12 + 8 * MAX_BYTES;
    localparam int unsigned FrameMax = HdrMax + CRC_WIDTH;
    localparam int unsigned CntW     = $clog2(FrameMax + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StSend, StDone} state_e;

    state_e                 state_q, state_d;
    logic [HdrMax-1:0]      hdr_vec, hdr_mask, calc_sr_q, calc_sr_d;
    logic [FrameMax-1:0]    tx_q, tx_d;
    logic [63:0]            mask_q, mask_d;
    logic                   inj_q, inj_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d, div_cnt_q, div_cnt_d;
    logic [CntW-1:0]        hdr_len_in, hdr_len_q, hdr_len_d;
    logic [CntW-1:0]        cnt_q, cnt_d, rem_q, rem_d;
    logic [CRC_WIDTH-1:0]   crc_q, crc_d, crc_next, crc_rev;
    logic                   crc_fb;
    logic                   busy_q, busy_d, done_q, done_d;
    logic                   clr_q, clr_d, len_err_q, len_err_d;
    logic [LANES-1:0]       dl_out_q, dl_out_d, dl_en_q, dl_en_d;

    // Lay the request out in wire order (vector bit k = frame bit k) and mask unused payload.
    always_comb begin
        hdr_vec = '0;
        for (int i = 0; i < 4; i++) hdr_vec[i] = msg_tag[3-i];
        for (int i = 0; i < 8; i++) hdr_vec[4+i] = msg_len[7-i];
        for (int b = 0; b < int'(MAX_BYTES); b++) begin
            for (int j = 0; j < 8; j++) hdr_vec[12+8*b+j] = data_in[b][7-j];
        end
        hdr_len_in = CntW'(12) + CntW'({msg_len, 3'b000});
        hdr_mask   = ~({HdrMax{1'b1}} << hdr_len_in);
    end

    // One CRC step on the next header bit; the reversed copy puts the CRC MSB at the lowest index.
    always_comb begin
        crc_fb   = crc_q[CRC_WIDTH-1] ^ calc_sr_q[0];
        crc_next = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
        for (int i = 0; i < int'(CRC_WIDTH); i++) crc_rev[i] = crc_next[CRC_WIDTH-1-i];
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        calc_sr_d = calc_sr_q;
        tx_d      = tx_q;
        mask_d    = mask_q;
        inj_d     = inj_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        hdr_len_d = hdr_len_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        crc_d     = crc_q;
        len_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (32'(msg_len) > MAX_BYTES) begin
                        len_err_d = 1'b1;
                    end else begin
                        state_d   = StCalc;
                        calc_sr_d = hdr_vec & hdr_mask;
                        tx_d      = FrameMax'(hdr_vec & hdr_mask);
                        mask_d    = {err_inj_mask_1, err_inj_mask_0};
                        inj_d     = err_inj_enable;
                        div_d     = ser_clk_div;
                        div_cnt_d = '0;
                        hdr_len_d = hdr_len_in;
                        cnt_d     = hdr_len_in;
                        rem_d     = hdr_len_in + CntW'(CRC_WIDTH);
                        crc_d     = CRC_INIT;
                    end
                end
            end
            StCalc: begin
                crc_d     = crc_next;
                calc_sr_d = calc_sr_q >> 1;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    // Header fully absorbed: append the final CRC behind it.
                    state_d   = StSend;
                    div_cnt_d = '0;
                    tx_d      = tx_q | (FrameMax'(crc_rev) << hdr_len_q);
                end
            end
            StSend: begin
                if (div_cnt_q == div_q) begin
                    div_cnt_d = '0;
                    if (rem_q <= CntW'(LANES)) begin
                        state_d = StDone;
                    end else begin
                        tx_d   = tx_q >> LANES;
                        mask_d = mask_q >> LANES;
                        rem_d  = rem_q - CntW'(LANES);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        clr_d    = (state_d == StDone) && inj_d;
        dl_en_d  = '0;
        dl_out_d = '0;
        // Low LANES bits of tx/mask always hold the current symbol; lanes past the end stay 0.
        for (int l = 0; l < int'(LANES); l++) begin
            dl_en_d[l]  = (state_d == StSend) && (CntW'(l) < rem_d);
            dl_out_d[l] = dl_en_d[l] & (tx_d[l] ^ (inj_d & mask_d[l]));
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            calc_sr_q <= '0;
            tx_q      <= '0;
            mask_q    <= '0;
            inj_q     <= 1'b0;
            div_q     <= '0;
            div_cnt_q <= '0;
            hdr_len_q <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            crc_q     <= CRC_INIT;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_q     <= 1'b0;
            len_err_q <= 1'b0;
            dl_out_q  <= '0;
            dl_en_q   <= '0;
        end else begin
            state_q   <= state_d;
            calc_sr_q <= calc_sr_d;
            tx_q      <= tx_d;
            mask_q    <= mask_d;
            inj_q     <= inj_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            hdr_len_q <= hdr_len_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            crc_q     <= crc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clr_q     <= clr_d;
            len_err_q <= len_err_d;
            dl_out_q  <= dl_out_d;
            dl_en_q   <= dl_en_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_inj_clear = clr_q;
    assign len_err       = len_err_q;
    assign crc_out       = crc_q;
    assign dl_out        = dl_out_q;
    assign dl_en         = dl_en_q;

endmodule

// File: tb/tb_dl_lane_serializer.sv
// Bench for dl_lane_serializer: a 2-lane and a 3-lane instance share all inputs and are
// compared cycle by cycle against a frame-level model, from a vector table, hand-written
// corner sequences and randomized frames.
module tb_dl_lane_serializer;

    localparam int MB = 16;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       clr;
        logic       lerr;
        logic [7:0] en;
        logic [7:0] out;
    } obs_t;

    typedef struct {
        logic [3:0]  tag;
        logic [7:0]  len;
        int          dv;
        bit          en;
        logic [31:0] a;
        logic [31:0] b;
        int          poke;
        int          lat2;
        int          lat3;
        logic [15:0] crc;
        bit          crc_known;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst, start, err_inj_enable;
    logic [3:0]          msg_tag;
    logic [7:0]          msg_len;
    logic [MB-1:0][7:0]  data_in;
    logic [7:0]          ser_clk_div;
    logic [31:0]         err_inj_mask_0, err_inj_mask_1;

    logic        clr2, busy2, done2, lerr2, clr3, busy3, done3, lerr3;
    logic [15:0] crc2, crc3;
    logic [1:0]  out2, en2;
    logic [2:0]  out3, en3;

    dl_lane_serializer #(.LANES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .msg_tag(msg_tag), .msg_len(msg_len),
        .data_in(data_in), .ser_clk_div(ser_clk_div), .err_inj_mask_0(err_inj_mask_0),
        .err_inj_mask_1(err_inj_mask_1), .err_inj_enable(err_inj_enable),
        .err_inj_clear(clr2), .busy(busy2), .done(done2), .len_err(lerr2),
        .crc_out(crc2), .dl_out(out2), .dl_en(en2)
    );

    dl_lane_serializer #(.LANES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .msg_tag(msg_tag), .msg_len(msg_len),
        .data_in(data_in), .ser_clk_div(ser_clk_div), .err_inj_mask_0(err_inj_mask_0),
        .err_inj_mask_1(err_inj_mask_1), .err_inj_enable(err_inj_enable),
        .err_inj_clear(clr3), .busy(busy3), .done(done3), .len_err(lerr3),
        .crc_out(crc3), .dl_out(out3), .dl_en(en3)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          fr[256];
    int          m_n, m_h, m_div;
    bit          m_inj;
    logic [15:0] m_crc;
    logic [1:0]  cap2[$];
    logic [2:0]  last_en3, last_out3;
    int          d2, d3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame model: bit list in wire order, CRC over the clean header, injection applied last.
    task automatic build_model(input logic [3:0] tag, input logic [7:0] len,
                               input logic [MB-1:0][7:0] d, input int dv, input bit en,
                               input logic [31:0] a, input logic [31:0] b);
        bit          q[$];
        logic [15:0] crc;
        logic [63:0] msk;
        bit          fbk;
        for (int i = 3; i >= 0; i--) q.push_back(tag[i]);
        for (int i = 7; i >= 0; i--) q.push_back(len[i]);
        for (int by = 0; by < int'(len); by++)
            for (int i = 7; i >= 0; i--) q.push_back(d[by][i]);
        crc = 16'hFFFF;
        foreach (q[k]) begin
            fbk = crc[15] ^ q[k];
            crc = crc << 1;
            if (fbk) crc = crc ^ 16'h1021;
        end
        m_crc = crc;
        m_h   = q.size();
        for (int i = 15; i >= 0; i--) q.push_back(crc[i]);
        m_n   = q.size();
        m_div = dv;
        m_inj = en;
        msk   = {b, a};
        for (int k = 0; k < m_n; k++) begin
            fr[k] = q[k];
            if (en && k < 64) fr[k] = q[k] ^ msk[k];
        end
    endtask

    function automatic int lat_of(int lanes);
        return 1 + m_h + ((m_n + lanes - 1) / lanes) * (m_div + 1);
    endfunction

    // Expected outputs in cycle c after the start edge (c = 1 is the first busy cycle).
    function automatic obs_t model_obs(int lanes, int c);
        obs_t o;
        int   lat, sym, k;
        o   = '0;
        lat = lat_of(lanes);
        if (c >= 1 && c <= lat) o.busy = 1'b1;
        if (c == lat) begin
            o.done = 1'b1;
            o.clr  = m_inj;
        end
        if (c > m_h && c < lat) begin
            sym = (c - m_h - 1) / (m_div + 1);
            for (int l = 0; l < lanes; l++) begin
                k = sym * lanes + l;
                if (k < m_n) begin
                    o.en[l]  = 1'b1;
                    o.out[l] = fr[k];
                end
            end
        end
        return o;
    endfunction

    task automatic scramble_inputs();
        msg_tag = 4'($urandom);
        msg_len = 8'($urandom_range(0, MB));
        for (int b = 0; b < MB; b++) data_in[b] = 8'($urandom);
        ser_clk_div    = 8'($urandom);
        err_inj_mask_0 = $urandom;
        err_inj_mask_1 = $urandom;
        err_inj_enable = 1'($urandom);
    endtask

    // Start one frame, then compare both instances every cycle until both are idle again.
    // poke > 0 raises start again in that cycle, which must be ignored.
    task automatic run_frame(input logic [3:0] tag, input logic [7:0] len,
                             input logic [MB-1:0][7:0] d, input int dv, input bit en,
                             input logic [31:0] a, input logic [31:0] b, input int poke);
        int   l2, l3, cmax;
        obs_t o2, o3;
        msg_tag = tag; msg_len = len; data_in = d; ser_clk_div = 8'(dv);
        err_inj_enable = en; err_inj_mask_0 = a; err_inj_mask_1 = b;
        start = 1'b1;
        build_model(tag, len, d, dv, en, a, b);
        l2 = lat_of(2);
        l3 = lat_of(3);
        cmax = ((l2 > l3) ? l2 : l3) + 2;
        d2 = 0; d3 = 0;
        cap2.delete();
        last_en3 = '0; last_out3 = '0;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        for (int c = 1; c <= cmax; c++) begin
            o2 = obs_t'({busy2, done2, clr2, lerr2, 6'b0, en2, 6'b0, out2});
            o3 = obs_t'({busy3, done3, clr3, lerr3, 5'b0, en3, 5'b0, out3});
            check($sformatf("L2 outputs cycle %0d", c), 64'(o2), 64'(model_obs(2, c)));
            check($sformatf("L3 outputs cycle %0d", c), 64'(o3), 64'(model_obs(3, c)));
            if (c == 1) begin
                check("L2 crc_out seeded", 64'(crc2), 64'(16'hFFFF));
                check("L3 crc_out seeded", 64'(crc3), 64'(16'hFFFF));
            end
            if (c == l2) check("L2 crc_out final", 64'(crc2), 64'(m_crc));
            if (c == l3) check("L3 crc_out final", 64'(crc3), 64'(m_crc));
            if (done2 && d2 == 0) d2 = c;
            if (done3 && d3 == 0) d3 = c;
            if (en2 != 2'b00) cap2.push_back(out2);
            if (en3 != 3'b000) begin
                last_en3  = en3;
                last_out3 = out3;
            end
            if (c == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    vec_t               tbl[4];
    logic [MB-1:0][7:0] pat;
    logic [7:0]         lane0_bits, lane1_bits;
    logic               saw;
    int                 h, n, ml, pk;
    logic [7:0]         rlen;
    int                 rdv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        msg_tag = '0; msg_len = '0; data_in = '0; ser_clk_div = '0;
        err_inj_mask_0 = '0; err_inj_mask_1 = '0; err_inj_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("L2 reset outputs", 64'({busy2, done2, clr2, lerr2, en2, out2}), 64'(0));
        check("L3 reset outputs", 64'({busy3, done3, clr3, lerr3, en3, out3}), 64'(0));
        check("L2 reset crc_out", 64'(crc2), 64'(16'hFFFF));
        check("L3 reset crc_out", 64'(crc3), 64'(16'hFFFF));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int b = 0; b < MB; b++) pat[b] = 8'(8'h3C + b * 37);
        tbl[0] = '{4'h0, 8'd0,  0, 1'b0, 32'h0,        32'h0,        0,   27,  23,  16'hFECE, 1'b1};
        tbl[1] = '{4'h0, 8'd0,  0, 1'b1, 32'h1,        32'h0,        0,   27,  23,  16'hFECE, 1'b1};
        tbl[2] = '{4'h5, 8'd16, 3, 1'b0, 32'h0,        32'h0,        200, 453, 349, 16'h0,    1'b0};
        tbl[3] = '{4'hA, 8'd5,  1, 1'b1, 32'hDEADBEEF, 32'hFFFF0000, 20,  121, 99,  16'h0,    1'b0};

        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].tag, tbl[i].len, pat, tbl[i].dv, tbl[i].en, tbl[i].a, tbl[i].b,
                      tbl[i].poke);
            check($sformatf("vec%0d L2 done latency", i), 64'(d2), 64'(tbl[i].lat2));
            check($sformatf("vec%0d L3 done latency", i), 64'(d3), 64'(tbl[i].lat3));
            if (tbl[i].crc_known) begin
                check($sformatf("vec%0d L2 crc", i), 64'(crc2), 64'(tbl[i].crc));
                check($sformatf("vec%0d L3 crc", i), 64'(crc3), 64'(tbl[i].crc));
            end
            if (i == 0) begin
                for (int s = 0; s < 8; s++) begin
                    lane0_bits[7-s] = cap2[6+s][0];
                    lane1_bits[7-s] = cap2[6+s][1];
                end
                check("L2 symbol count", 64'(cap2.size()), 64'(14));
                check("L2 lane0 bits 12..26", 64'(lane0_bits), 64'(8'b1111_1011));
                check("L2 lane1 bits 13..27", 64'(lane1_bits), 64'(8'b1110_1010));
                check("L3 last symbol dl_en", 64'(last_en3), 64'(3'b001));
                check("L3 last symbol dl_out[2:1]", 64'(last_out3[2:1]), 64'(2'b00));
            end
            if (i == 1) check("L2 injected first lane0 bit", 64'(cap2[0][0]), 64'(1));
        end

        // Oversized length is rejected with a single len_err pulse.
        msg_len = 8'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("L2 len_err pulse", 64'({lerr2, busy2}), 64'(2'b10));
        check("L3 len_err pulse", 64'({lerr3, busy3}), 64'(2'b10));
        @(posedge clk); #1;
        check("L2 len_err one cycle", 64'({lerr2, busy2}), 64'(2'b00));

        // Reset in the middle of SEND: outputs return to reset values, no done pulse follows.
        msg_tag = 4'h0; msg_len = 8'd0; ser_clk_div = 8'd2; err_inj_enable = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("L2 sending before reset", 64'({busy2, en2}), 64'(3'b111));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("L2 after mid-send reset", 64'({busy2, done2, clr2, en2, out2}), 64'(0));
        check("L3 after mid-send reset", 64'({busy3, done3, clr3, en3, out3}), 64'(0));
        check("L2 crc after mid-send reset", 64'(crc2), 64'(16'hFFFF));
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            saw = saw | done2 | done3 | clr2 | clr3 | busy2 | busy3;
            @(posedge clk); #1;
        end
        check("no activity after reset", 64'(saw), 64'(0));

        // Randomized frames against the model.
        for (int r = 0; r < 24; r++) begin
            rlen = 8'($urandom_range(0, MB));
            rdv  = $urandom_range(0, 3);
            for (int b = 0; b < MB; b++) pat[b] = 8'($urandom);
            h  = 12 + 8 * int'(rlen);
            n  = h + 16;
            ml = 1 + h + ((n + 2) / 3) * (rdv + 1);
            pk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ml - 1) : 0;
            run_frame(4'($urandom), rlen, pat, rdv, 1'($urandom), $urandom, $urandom, pk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_lane_serializer.md
# dl_lane_serializer

Parametrised multi-lane downlink serializer, the next generation of the single-lane downlink controller in the FEC datapath. It snapshots a tagged message from the registered UART RX array and frames it as tag, length, payload and CRC. The frame is striped across `LANES` serial outputs at a programmable symbol rate, with optional XOR error injection on the first 64 frame bits. The FEC control FSM drives `start` and waits for `done`; the register block supplies the divider and the error-injection masks.

## Interface
Parameters:
- `LANES`, 2, number of parallel serial lanes (1..8)
- `MAX_BYTES`, 16, payload capacity in bytes
- `DIV_WIDTH`, 8, width of the symbol-rate divider
- `CRC_WIDTH`, 16, CRC register width
- `CRC_POLY`, 16'h1021, CRC polynomial (implicit top bit)
- `CRC_INIT`, 16'hFFFF, CRC seed

Ports:
- `clk`  in  1  single clock domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  frame request; sampled only in IDLE
- `msg_tag`  in  4  frame tag
- `msg_len`  in  8  payload length in bytes (0..MAX_BYTES)
- `data_in`  in  MAX_BYTES×8 (packed [MAX_BYTES-1:0][7:0])  payload; byte 0 is sent first
- `ser_clk_div`  in  DIV_WIDTH  each symbol lasts ser_clk_div+1 clk cycles
- `err_inj_mask_0`  in  32  XOR mask for frame bits 0..31
- `err_inj_mask_1`  in  32  XOR mask for frame bits 32..63
- `err_inj_enable`  in  1  apply the masks to this frame
- `err_inj_clear`  out  1  1-cycle pulse; the injection was consumed
- `busy`  out  1  high outside IDLE
- `done`  out  1  1-cycle pulse when the frame completes
- `len_err`  out  1  1-cycle pulse; start was rejected (msg_len > MAX_BYTES)
- `crc_out`  out  CRC_WIDTH  CRC of the current or last frame
- `dl_out`  out  LANES  serial data, one bit per lane
- `dl_en`  out  LANES  per-lane valid for `dl_out`

## Operation
- Frame bit sequence, index 0 first:
  - tag[3:0], MSB first;
  - len[7:0], MSB first;
  - payload bytes 0..len-1, each MSB first;
  - CRC, MSB first.
- Frame length N = 12 + 8·len + CRC_WIDTH.
- On an accepted start, all inputs are snapshotted: tag, len, data_in, divider, both masks and enable. Input changes after that have no effect on the frame.
- CRC is computed bit-serially over bits 0..11+8·len of the uncorrupted frame:
  - fb = crc[MSB] ^ bit;
  - crc = crc << 1;
  - if fb, crc ^= CRC_POLY.
- Error injection: when the snapshotted enable is 1, frame bit k (k < 64) is XORed with mask bit k before output. The CRC is never recomputed after injection.
- Lane striping: frame bit k goes to lane k mod LANES, in symbol k div LANES. Symbol count S = ceil(N/LANES).
- In the last symbol, lanes without a bit drive `dl_out`=0 and `dl_en`=0.
- State machine:
  - IDLE: on start with msg_len ≤ MAX_BYTES, go to CALC. On start with msg_len > MAX_BYTES, pulse `len_err` and stay in IDLE.
  - CALC: 12+8·len cycles, one CRC bit per cycle. Then go to SEND.
  - SEND: S symbols, each held ser_clk_div+1 cycles. Then go to DONE.
  - DONE: 1 cycle; `done`=1; `err_inj_clear`=1 if the injection was applied. Then go to IDLE.
- `start` in any state other than IDLE is ignored.
- `crc_out` loads CRC_INIT at an accepted start, updates during CALC, and holds until the next accepted start.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `len_err`, `err_inj_clear` = 0; `dl_out`, `dl_en` = 0; `crc_out` = CRC_INIT.
- All outputs are registered.
- Start accepted at edge t: `busy`=1 from t+1; CALC occupies cycles t+1 .. t+12+8·len.
- `dl_en`/`dl_out` for the first symbol are valid from the first SEND cycle. Each symbol is stable for exactly ser_clk_div+1 cycles.
- `dl_en`=0 outside SEND.
- `done` is asserted the cycle after the last symbol ends. `busy` falls together with `done`. A new start can be accepted in the cycle after `done`.
- Total latency from start to done = 1 + (12+8·len) + S·(ser_clk_div+1) cycles.
- `rst` during any state: at the next edge, return to IDLE with reset values. No `done` or `err_inj_clear` pulse is generated.
- `ser_clk_div`=0: one symbol per cycle, with no gap between symbols.

## Test plan
- LANES=2, tag=0, len=0, div=0:
  - `crc_out`=0xFECE; N=28, S=14; done 27 cycles after start;
  - lane0 bits 12..26 = 1,1,1,1,1,0,1,1; lane1 bits 13..27 = 1,1,1,0,1,0,1,0.
- Same frame with err_inj_enable=1, mask_0=32'h1:
  - the first lane0 bit = 1;
  - `crc_out` is still 0xFECE;
  - `err_inj_clear` pulses together with `done`.
- LANES=3, tag=0, len=0: S=10; the last symbol has `dl_en`=3'b001 and `dl_out`[2:1]=0.
- LANES=2, len=16, div=3: every symbol is held 4 cycles; done arrives 1+140+78·4 = 453 cycles after start.
- msg_len=17 → `len_err` pulses, `busy` stays 0. A second start during SEND is ignored; exactly one `done` is produced.
- Assert `rst` mid-SEND → next cycle `dl_en`=0, `busy`=0, `crc_out`=0xFFFF, and no `done` pulse.
